// File: rtl/pattern_gen_engine.sv
// pattern_gen_engine: frame/line sequencer with x/y counters and test-pattern pixel generator.
// Rev 1.0 - initial release.
`default_nettype none

module pattern_gen_engine #(
  parameter int PIX_W       = 12,
  parameter int LINE_LEN    = 64,
  parameter int FRAME_LINES = 32,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_sync_i,
  input  logic             sync_i,
  input  logic [2:0]       mode_i,
  input  logic             gray_en_i,
  input  logic [1:0]       cb_log2_i,
  input  logic [PIX_W-1:0] const_val_i,
  input  logic [1:0]       dx_i,
  input  logic [PIX_W-1:0] dy_i,
  output logic             pix_valid_o,
  output logic [PIX_W-1:0] pix_data_o,
  output logic             line_end_o,
  output logic             frame_end_o,
  output logic             busy_o,
  output logic             sync_err_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(FRAME_LINES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic [PIX_W-1:0]   row_q, row_d;
  logic [PIX_W-1:0]   acc_q, acc_d;

  logic [2:0]         mode_q, mode_d;
  logic               gray_q, gray_d;
  logic [1:0]         cb_q, cb_d;
  logic [PIX_W-1:0]   cval_q, cval_d;
  logic [1:0]         dx_q, dx_d;
  logic [PIX_W-1:0]   dy_q, dy_d;

  logic               valid_q, valid_d;
  logic [PIX_W-1:0]   data_q, data_d;
  logic               le_q, le_d;
  logic               fe_q, fe_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [PIX_W-1:0]   step;
  logic [CNT_W-1:0]   x_inc;
  logic [PIX_W-1:0]   acc_inc;

  // Pixel value for pixel x of line y, using the configuration latched at frame start.
  function automatic logic [PIX_W-1:0] pixel_f(
    input logic [2:0]       m,
    input logic             g,
    input logic [1:0]       cb,
    input logic [PIX_W-1:0] cv,
    input logic [CNT_W-1:0] x,
    input logic [CNT_W-1:0] y,
    input logic [PIX_W-1:0] acc
  );
    logic [PIX_W-1:0] xp;
    logic [CNT_W-1:0] xs;
    logic [CNT_W-1:0] ys;
    logic             c;
    xp = PIX_W'(x);
    xs = x >> cb;
    ys = y >> cb;
    c  = xs[0] ^ ys[0];
    case (m)
      3'd0:    pixel_f = g ? (xp ^ (xp >> 1)) : xp;
      3'd1:    pixel_f = cv;
      3'd2:    pixel_f = c ? '0 : '1;
      3'd3:    pixel_f = c ? '1 : '0;
      3'd4:    pixel_f = acc;
      default: pixel_f = '0;
    endcase
  endfunction

  always_comb begin
    case (dx_q)
      2'd0:    step = '0;
      2'd1:    step = PIX_W'(1);
      2'd2:    step = PIX_W'(4);
      default: step = PIX_W'(8);
    endcase
  end

  assign x_inc   = x_q + CNT_W'(1);
  assign acc_inc = acc_q + step;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    gray_d  = gray_q;
    cb_d    = cb_q;
    cval_d  = cval_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    valid_d = 1'b0;
    data_d  = data_q;
    le_d    = 1'b0;
    fe_d    = 1'b0;
    err_d   = sync_i && (state_q != WAIT_LINE);

    // f_sync has priority in every state: restart the frame with fresh configuration.
    if (f_sync_i) begin
      mode_d  = mode_i;
      gray_d  = gray_en_i;
      cb_d    = cb_log2_i;
      cval_d  = const_val_i;
      dx_d    = dx_i;
      dy_d    = dy_i;
      y_d     = '0;
      row_d   = '0;
      state_d = WAIT_LINE;
    end else begin
      case (state_q)
        WAIT_LINE: begin
          if (sync_i) begin
            state_d = ACTIVE;
            x_d     = '0;
            acc_d   = row_q;
            valid_d = 1'b1;
            data_d  = pixel_f(mode_q, gray_q, cb_q, cval_q, '0, y_q, row_q);
          end
        end
        ACTIVE: begin
          if (x_q == LAST_X) begin
            if (y_q == LAST_Y) begin
              state_d = IDLE;
            end else begin
              y_d     = y_q + CNT_W'(1);
              row_d   = row_q + dy_q;
              state_d = WAIT_LINE;
            end
          end else begin
            x_d     = x_inc;
            acc_d   = acc_inc;
            valid_d = 1'b1;
            data_d  = pixel_f(mode_q, gray_q, cb_q, cval_q, x_inc, y_q, acc_inc);
            le_d    = (x_inc == LAST_X);
            fe_d    = (x_inc == LAST_X) && (y_q == LAST_Y);
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      mode_q  <= '0;
      gray_q  <= 1'b0;
      cb_q    <= '0;
      cval_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      le_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      gray_q  <= gray_d;
      cb_q    <= cb_d;
      cval_q  <= cval_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      le_q    <= le_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign pix_valid_o = valid_q;
  assign pix_data_o  = data_q;
  assign line_end_o  = le_q;
  assign frame_end_o = fe_q;
  assign busy_o      = busy_q;
  assign sync_err_o  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_gen_engine.sv
// tb_pattern_gen_engine: directed bench with an expected-pixel queue for pattern_gen_engine.
// Rev 1.0 - initial release.
`default_nettype none

module tb_pattern_gen_engine;

  localparam int PW = 12;
  localparam int LL = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_sync_i, sync_i, gray_en_i;
  logic [2:0]    mode_i;
  logic [1:0]    cb_log2_i, dx_i;
  logic [PW-1:0] const_val_i, dy_i;
  logic          pix_valid_o, line_end_o, frame_end_o, busy_o, sync_err_o;
  logic [PW-1:0] pix_data_o;

  pattern_gen_engine #(.PIX_W(PW), .LINE_LEN(LL), .FRAME_LINES(FL), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .f_sync_i(f_sync_i), .sync_i(sync_i),
    .mode_i(mode_i), .gray_en_i(gray_en_i), .cb_log2_i(cb_log2_i),
    .const_val_i(const_val_i), .dx_i(dx_i), .dy_i(dy_i),
    .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o), .line_end_o(line_end_o),
    .frame_end_o(frame_end_o), .busy_o(busy_o), .sync_err_o(sync_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          le;
    logic          fe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Configuration the DUT should have latched at the most recent f_sync, and current line.
  int            lm_mode, lm_gray, lm_cb, lm_dx, ym;
  logic [PW-1:0] lm_cv, lm_dy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model_pix(input int x, input int y);
    int v, c, st;
    case (lm_dx)
      0: st = 0;
      1: st = 1;
      2: st = 4;
      default: st = 8;
    endcase
    c = ((x >> lm_cb) ^ (y >> lm_cb)) & 1;
    case (lm_mode)
      0: v = (lm_gray != 0) ? (x ^ (x >> 1)) : x;
      1: v = int'(lm_cv);
      2: v = (c != 0) ? 0 : 'hFFF;
      3: v = (c != 0) ? 'hFFF : 0;
      4: v = y * int'(lm_dy) + x * st;
      default: v = 0;
    endcase
    return v[PW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch_model();
    lm_mode = int'(mode_i);
    lm_gray = int'(gray_en_i);
    lm_cb   = int'(cb_log2_i);
    lm_cv   = const_val_i;
    lm_dx   = int'(dx_i);
    lm_dy   = dy_i;
    ym      = 0;
  endtask

  task automatic do_fsync();
    f_sync_i = 1'b1;
    latch_model();
    tick();
    f_sync_i = 1'b0;
    chk("busy_after_fsync", busy_o, 1);
    tick();
  endtask

  // abort_at / sync_at: pixel index during which f_sync / sync is presented (-1 = none).
  task automatic do_line(input int abort_at, input int sync_at);
    int   n;
    bit   aborted;
    exp_t e;
    n = (abort_at >= 0 && abort_at < LL - 1) ? abort_at + 1 : LL;
    for (int x = 0; x < n; x++) begin
      e.d  = model_pix(x, ym);
      e.le = (x == LL - 1);
      e.fe = (x == LL - 1) && (ym == FL - 1);
      sb.push_back(e);
    end
    aborted = 1'b0;
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    for (int k = 0; k < LL + 1; k++) begin
      if (k == abort_at) begin
        f_sync_i = 1'b1;
        aborted  = 1'b1;
      end
      if (k == sync_at) sync_i = 1'b1;
      tick();
      f_sync_i = 1'b0;
      if (k == sync_at) begin
        chk("sync_err_active", sync_err_o, 1);
        sync_i = 1'b0;
      end
    end
    chk("valid_after_line", pix_valid_o, 0);
    chk("sb_drained", sb.size(), 0);
    if (aborted) begin
      latch_model();
      chk("busy_after_abort", busy_o, 1);
    end else if (ym == FL - 1) begin
      chk("busy_after_frame", busy_o, 0);
    end else begin
      chk("busy_between_lines", busy_o, 1);
      ym++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_pix", pix_valid_o, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pix_data", pix_data_o, e.d);
          chk("line_end", line_end_o, e.le);
          chk("frame_end", frame_end_o, e.fe);
        end
      end else if (line_end_o || frame_end_o) begin
        chk("end_flag_no_valid", {line_end_o, frame_end_o}, 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; f_sync_i = 1'b0; sync_i = 1'b0; mode_i = 3'd0; gray_en_i = 1'b0;
    cb_log2_i = 2'd0; const_val_i = '0; dx_i = 2'd0; dy_i = '0;
    lm_mode = 0; lm_gray = 0; lm_cb = 0; lm_dx = 0; lm_cv = '0; lm_dy = '0; ym = 0;
    repeat (3) tick();
    chk("rst_outputs", {pix_valid_o, pix_data_o, line_end_o, frame_end_o, busy_o, sync_err_o}, 0);
    rst_n = 1'b1;
    tick();

    // Gray counter frame
    mode_i = 3'd0; gray_en_i = 1'b1;
    do_fsync();
    for (int l = 0; l < FL; l++) do_line(-1, -1);

    // Reset in the middle of an active line
    gray_en_i = 1'b0;
    do_fsync();
    for (int x = 0; x < LL; x++) sb.push_back('{model_pix(x, 0), x == LL - 1, 1'b0});
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {pix_valid_o, pix_data_o, line_end_o, frame_end_o, busy_o, sync_err_o}, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    chk("idle_sync_err", sync_err_o, 1);
    chk("idle_sync_novalid", pix_valid_o, 0);
    tick();
    chk("idle_sync_err_pulse", sync_err_o, 0);
    chk("idle_still_novalid", pix_valid_o, 0);
    chk("idle_not_busy", busy_o, 0);

    // Checkerboard, white first, 2x2 cells
    mode_i = 3'd2; cb_log2_i = 2'd1;
    do_fsync();
    for (int l = 0; l < FL; l++) do_line(-1, -1);

    // Checkerboard, black first, 1x1 cells; frame left in WAIT_LINE
    mode_i = 3'd3; cb_log2_i = 2'd0;
    do_fsync();
    do_line(-1, -1);
    do_line(-1, -1);

    // Ramp, f_sync from WAIT_LINE
    mode_i = 3'd4; dx_i = 2'd2; dy_i = 12'h010;
    do_fsync();
    for (int l = 0; l < FL; l++) do_line(-1, -1);
    dy_i = 12'hFF8;
    do_fsync();
    for (int l = 0; l < FL; l++) do_line(-1, -1);

    // Sync inside a line, then config change mid-frame, then abort at x=5 of line 2
    mode_i = 3'd0; gray_en_i = 1'b0;
    do_fsync();
    do_line(-1, 3);
    mode_i = 3'd1; const_val_i = 12'hABC;
    do_line(-1, -1);
    do_line(5, -1);
    for (int l = 0; l < FL; l++) do_line(-1, -1);

    // f_sync coinciding with the last pixel of a line
    mode_i = 3'd2; cb_log2_i = 2'd0;
    do_fsync();
    do_line(-1, -1);
    do_line(LL - 1, -1);
    do_line(-1, -1);

    repeat (2) tick();
    chk("sb_final_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
